// File: rtl/accel_bridge_pkg.sv
// Shared types and helpers for the accelerator command bridge.
// Optional watchdog build: define ACCEL_BRIDGE_WATCHDOG_EN.
package accel_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      BUSY = 2'd2,
      DONE = 2'd3
   } bridge_state_t;

   localparam int CFG_ADDR_W = 3;

   // Pointer width with one extra wrap bit to tell full from empty.
   function automatic int fifo_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/accel_cmd_bridge_fifo.sv
// Synchronous first-word-fall-through FIFO buffering CPU bus writes.
// A push while full is accepted only when a pop happens in the same cycle.
// Flush empties the FIFO and overrides any push or pop in that cycle.
module bridge_fifo
   import accel_bridge_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = fifo_ptr_w(DEPTH);
   localparam int IDX_W = PTR_W - 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_d;
   logic              do_push_s;
   logic              do_pop_s;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
   assign dout  = mem_q[rd_ptr_q[IDX_W-1:0]];

   assign do_pop_s  = pop && !empty && !flush;
   assign do_push_s = push && !flush && (!full || do_pop_s);

   // Pointer next-state: flush wins, otherwise advance on accepted push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, written at the write pointer on an accepted push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push_s) begin
         mem_q[wr_ptr_q[IDX_W-1:0]] <= din;
      end
   end

endmodule

// File: rtl/accel_cmd_bridge.sv
// Accelerator command bridge: buffers CPU bus writes, streams them into the
// accelerator config bank at auto-incrementing addresses, starts the run and
// reports completion back to the CPU.
// Optional watchdog: define ACCEL_BRIDGE_WATCHDOG_EN to time out a stuck run.
module accel_cmd_bridge
   import accel_bridge_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int NUM_REGS       = 6,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  accel_en,
   input  logic                  bus_wr,
   input  logic [DATA_W-1:0]     bus_data,
   output logic                  accel_done,
   output logic                  cfg_we,
   output logic [CFG_ADDR_W-1:0] cfg_addr,
   output logic [DATA_W-1:0]     cfg_data,
   output logic                  acc_start,
   input  logic                  acc_finish,
   output logic                  overflow,
   output logic                  timeout
);

   localparam logic [CFG_ADDR_W-1:0] LAST_IDX = CFG_ADDR_W'(NUM_REGS - 1);
   localparam logic [CFG_ADDR_W-1:0] IDX_ONE  = CFG_ADDR_W'(1);

   bridge_state_t         state_q;
   bridge_state_t         state_d;
   logic [CFG_ADDR_W-1:0] cnt_q;
   logic [CFG_ADDR_W-1:0] cnt_d;
   logic                  start_pend_q;
   logic                  start_pend_d;
   logic                  accel_done_q;
   logic                  accel_done_d;
   logic                  cfg_we_q;
   logic                  cfg_we_d;
   logic [CFG_ADDR_W-1:0] cfg_addr_q;
   logic [CFG_ADDR_W-1:0] cfg_addr_d;
   logic [DATA_W-1:0]     cfg_data_q;
   logic [DATA_W-1:0]     cfg_data_d;
   logic                  acc_start_q;
   logic                  acc_start_d;
   logic                  overflow_q;
   logic                  overflow_d;
   logic                  timeout_q;
   logic                  timeout_d;

   logic                  push_s;
   logic                  pop_s;
   logic                  flush_s;
   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic [DATA_W-1:0]     fifo_dout_s;

`ifdef ACCEL_BRIDGE_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   logic [WD_W-1:0] wd_cnt_q;
   logic [WD_W-1:0] wd_cnt_d;
`endif

   // Disabling the bridge drops incoming words and empties the buffer.
   assign push_s  = bus_wr && accel_en;
   assign flush_s = !accel_en;

   bridge_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush_s),
      .push  (push_s),
      .pop   (pop_s),
      .din   (bus_data),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Pop whenever a word is waiting and the bridge is accepting config words;
   // the cycle between the last config write and the start pulse is held off.
   always_comb begin
      pop_s = 1'b0;
      if (accel_en && !fifo_empty_s && !start_pend_q) begin
         case (state_q)
            IDLE, LOAD, DONE: pop_s = 1'b1;
            default:          pop_s = 1'b0;
         endcase
      end else begin
         pop_s = 1'b0;
      end
   end

   // Command FSM, word counter and output next-state.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      start_pend_d = 1'b0;
      accel_done_d = accel_done_q;
      cfg_we_d     = 1'b0;
      cfg_addr_d   = cfg_addr_q;
      cfg_data_d   = cfg_data_q;
      acc_start_d  = 1'b0;
      overflow_d   = overflow_q;
`ifdef ACCEL_BRIDGE_WATCHDOG_EN
      timeout_d    = timeout_q;
      wd_cnt_d     = wd_cnt_q;
`else
      timeout_d    = 1'b0;
`endif

      if (!accel_en) begin
         // Abort: back to a clean idle bridge, sticky flags included.
         state_d      = IDLE;
         cnt_d        = '0;
         accel_done_d = 1'b0;
         cfg_addr_d   = '0;
         cfg_data_d   = '0;
         overflow_d   = 1'b0;
         timeout_d    = 1'b0;
`ifdef ACCEL_BRIDGE_WATCHDOG_EN
         wd_cnt_d     = '0;
`endif
      end else begin
         if (push_s && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
         end else begin
            overflow_d = overflow_q;
         end

         if (pop_s) begin
            cfg_we_d     = 1'b1;
            cfg_addr_d   = cnt_q;
            cfg_data_d   = fifo_dout_s;
            accel_done_d = 1'b0;
            if (cnt_q == LAST_IDX) begin
               cnt_d        = '0;
               start_pend_d = 1'b1;
            end else begin
               cnt_d        = cnt_q + IDX_ONE;
            end
         end else begin
            cnt_d = cnt_q;
         end

         case (state_q)
            IDLE: begin
               if (pop_s) begin
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
            LOAD: begin
               if (start_pend_q) begin
                  state_d     = BUSY;
                  acc_start_d = 1'b1;
`ifdef ACCEL_BRIDGE_WATCHDOG_EN
                  wd_cnt_d    = '0;
`endif
               end else begin
                  state_d = LOAD;
               end
            end
            BUSY: begin
               if (acc_finish) begin
                  state_d      = DONE;
                  accel_done_d = 1'b1;
`ifdef ACCEL_BRIDGE_WATCHDOG_EN
               end else if (wd_cnt_q == WD_LAST) begin
                  state_d      = DONE;
                  accel_done_d = 1'b1;
                  timeout_d    = 1'b1;
               end else begin
                  wd_cnt_d = wd_cnt_q + WD_ONE;
               end
`else
               end else begin
                  state_d = BUSY;
               end
`endif
            end
            DONE: begin
               if (pop_s) begin
                  state_d = LOAD;
               end else begin
                  state_d = DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         start_pend_q <= 1'b0;
         accel_done_q <= 1'b0;
         cfg_we_q     <= 1'b0;
         cfg_addr_q   <= '0;
         cfg_data_q   <= '0;
         acc_start_q  <= 1'b0;
         overflow_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         start_pend_q <= start_pend_d;
         accel_done_q <= accel_done_d;
         cfg_we_q     <= cfg_we_d;
         cfg_addr_q   <= cfg_addr_d;
         cfg_data_q   <= cfg_data_d;
         acc_start_q  <= acc_start_d;
         overflow_q   <= overflow_d;
         timeout_q    <= timeout_d;
      end
   end

`ifdef ACCEL_BRIDGE_WATCHDOG_EN
   // Watchdog cycle counter for the BUSY phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end
`endif

   assign accel_done = accel_done_q;
   assign cfg_we     = cfg_we_q;
   assign cfg_addr   = cfg_addr_q;
   assign cfg_data   = cfg_data_q;
   assign acc_start  = acc_start_q;
   assign overflow   = overflow_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_accel_cmd_bridge.sv
// Directed self-checking bench for accel_cmd_bridge (NUM_REGS=6, FIFO_DEPTH=4).
// Watchdog expectations follow ACCEL_BRIDGE_WATCHDOG_EN (TIMEOUT_CYCLES=16).
module tb_accel_cmd_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        accel_en = 1'b0;
   logic        bus_wr = 1'b0;
   logic [15:0] bus_data = 16'h0000;
   logic        acc_finish = 1'b0;
   logic        accel_done;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        acc_start;
   logic        overflow;
   logic        timeout;

   int errors = 0;
   int checks = 0;

   accel_cmd_bridge #(
      .DATA_W         (16),
      .NUM_REGS       (6),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .accel_en   (accel_en),
      .bus_wr     (bus_wr),
      .bus_data   (bus_data),
      .accel_done (accel_done),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .acc_start  (acc_start),
      .acc_finish (acc_finish),
      .overflow   (overflow),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_time_limit: bench did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Writes six back-to-back words, then waits (bounded) for acc_start.
   task automatic load_cmd(input logic [15:0] base, output bit found);
      found = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus_wr   = 1'b1;
         bus_data = base + 16'(i);
         tick();
      end
      bus_wr = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (!found) begin
            if (acc_start === 1'b1) found = 1'b1;
            else tick();
         end
      end
   endtask

   task automatic test_reset();
      logic [24:0] outs;
      rst_n = 1'b0; accel_en = 1'b1; bus_wr = 1'b0; acc_finish = 1'b0;
      tick(); tick();
      outs = {accel_done, cfg_we, cfg_addr, cfg_data, acc_start, overflow, timeout};
      checks++;
      if (outs !== 25'd0) begin
         errors++; $display("FAIL reset_outputs: got %h want 0", outs);
      end
      rst_n = 1'b1;
      tick();
      outs = {accel_done, cfg_we, cfg_addr, cfg_data, acc_start, overflow, timeout};
      checks++;
      if (outs !== 25'd0) begin
         errors++; $display("FAIL reset_release_outputs: got %h want 0", outs);
      end
   endtask

   task automatic test_cmd_load();
      int c;
      logic exp_we;
      for (int cyc = 0; cyc < 10; cyc++) begin
         bus_wr   = (cyc < 6);
         bus_data = 16'h0010 + 16'(cyc);
         tick();
         c = cyc + 1;
         exp_we = (c >= 2) && (c <= 7);
         checks++;
         if (cfg_we !== exp_we) begin
            errors++; $display("FAIL load_we c=%0d: got %b want %b", c, cfg_we, exp_we);
         end
         if (exp_we) begin
            checks++;
            if (cfg_addr !== 3'(c - 2) || cfg_data !== 16'h0010 + 16'(c - 2)) begin
               errors++;
               $display("FAIL load_word c=%0d: got addr %0d data %h want addr %0d data %h",
                        c, cfg_addr, cfg_data, c - 2, 16'h0010 + 16'(c - 2));
            end
         end
         checks++;
         if (acc_start !== (c == 8)) begin
            errors++; $display("FAIL load_start c=%0d: got %b want %b", c, acc_start, (c == 8));
         end
      end
      bus_wr = 1'b0;
   endtask

   task automatic test_completion();
      // Now 2 cycles after acc_start; finish is driven 10 cycles after it.
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (accel_done !== 1'b0) begin
            errors++; $display("FAIL busy_done_low k=%0d: got %b want 0", k, accel_done);
         end
         tick();
      end
      acc_finish = 1'b1;
      tick();
      acc_finish = 1'b0;
      checks++;
      if (accel_done !== 1'b1) begin
         errors++; $display("FAIL done_rise: got %b want 1", accel_done);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (accel_done !== 1'b1) begin
            errors++; $display("FAIL done_hold k=%0d: got %b want 1", k, accel_done);
         end
      end
      bus_wr = 1'b1; bus_data = 16'hAAAA;
      tick();
      bus_wr = 1'b0;
      checks++;
      if (accel_done !== 1'b1 || cfg_we !== 1'b0) begin
         errors++; $display("FAIL done_before_pop: got done %b we %b want 1 0", accel_done, cfg_we);
      end
      tick();
      checks++;
      if (cfg_we !== 1'b1 || cfg_addr !== 3'd0 || cfg_data !== 16'hAAAA || accel_done !== 1'b0) begin
         errors++;
         $display("FAIL new_cmd_first: got we %b addr %0d data %h done %b want 1 0 aaaa 0",
                  cfg_we, cfg_addr, cfg_data, accel_done);
      end
   endtask

   task automatic test_overflow();
      bit found;
      for (int i = 0; i < 5; i++) begin
         bus_wr = 1'b1; bus_data = 16'h0100 + 16'(i + 1);
         tick();
      end
      bus_wr = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (!found) begin
            if (acc_start === 1'b1) found = 1'b1;
            else tick();
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL ovf_start_wait: got no acc_start want pulse");
      end
      for (int i = 0; i < 5; i++) begin
         bus_wr = 1'b1; bus_data = 16'hB000 + 16'(i);
         tick();
         checks++;
         if (cfg_we !== 1'b0) begin
            errors++; $display("FAIL busy_no_pop i=%0d: got %b want 0", i, cfg_we);
         end
         if (i >= 3) begin
            checks++;
            if (overflow !== (i == 4)) begin
               errors++; $display("FAIL overflow_set i=%0d: got %b want %b", i, overflow, (i == 4));
            end
         end
      end
      bus_wr = 1'b0; acc_finish = 1'b1;
      tick();
      acc_finish = 1'b0;
      checks++;
      if (accel_done !== 1'b1) begin
         errors++; $display("FAIL ovf_done: got %b want 1", accel_done);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (cfg_we !== 1'b1 || cfg_addr !== 3'(k) || cfg_data !== 16'hB000 + 16'(k) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain k=%0d: got we %b addr %0d data %h ovf %b want 1 %0d %h 1",
                     k, cfg_we, cfg_addr, cfg_data, overflow, k, 16'hB000 + 16'(k));
         end
      end
      tick();
      checks++;
      if (cfg_we !== 1'b0) begin
         errors++; $display("FAIL drain_end: got %b want 0", cfg_we);
      end
   endtask

   task automatic test_abort();
      int c;
      logic exp_we;
      logic [24:0] outs;
      accel_en = 1'b0;
      tick();
      accel_en = 1'b1;
      outs = {accel_done, cfg_we, cfg_addr, cfg_data, acc_start, overflow, timeout};
      checks++;
      if (outs !== 25'd0) begin
         errors++; $display("FAIL abort_clear: got %h want 0", outs);
      end
      for (int cyc = 0; cyc < 8; cyc++) begin
         accel_en = (cyc != 4);
         bus_wr   = (cyc <= 4);
         bus_data = 16'h00C0 + 16'(cyc);
         tick();
         c = cyc + 1;
         exp_we = (c >= 2) && (c <= 4);
         checks++;
         if (cfg_we !== exp_we) begin
            errors++; $display("FAIL abort_we c=%0d: got %b want %b", c, cfg_we, exp_we);
         end
         if (exp_we) begin
            checks++;
            if (cfg_addr !== 3'(c - 2) || cfg_data !== 16'h00C0 + 16'(c - 2)) begin
               errors++; $display("FAIL abort_word c=%0d: got %0d %h", c, cfg_addr, cfg_data);
            end
         end
         if (c == 5) begin
            outs = {accel_done, cfg_we, cfg_addr, cfg_data, acc_start, overflow, timeout};
            checks++;
            if (outs !== 25'd0) begin
               errors++; $display("FAIL abort_mid_clear: got %h want 0", outs);
            end
         end
      end
      accel_en = 1'b1;
      bus_wr = 1'b1; bus_data = 16'h00D0;
      tick();
      bus_wr = 1'b0;
      tick();
      checks++;
      if (cfg_we !== 1'b1 || cfg_addr !== 3'd0 || cfg_data !== 16'h00D0) begin
         errors++; $display("FAIL abort_restart: got we %b addr %0d data %h want 1 0 00d0",
                            cfg_we, cfg_addr, cfg_data);
      end
      accel_en = 1'b0;
      tick();
      accel_en = 1'b1;
   endtask

   task automatic test_simultaneous();
      bit found;
      load_cmd(16'h0E00, found);
      checks++;
      if (!found) begin
         errors++; $display("FAIL sim_start_wait: got no acc_start want pulse");
      end
      for (int i = 0; i < 4; i++) begin
         bus_wr = 1'b1; bus_data = 16'h00E0 + 16'(i);
         tick();
      end
      bus_wr = 1'b0; acc_finish = 1'b1;
      tick();
      acc_finish = 1'b0;
      checks++;
      if (accel_done !== 1'b1) begin
         errors++; $display("FAIL sim_done: got %b want 1", accel_done);
      end
      bus_wr = 1'b1; bus_data = 16'h00E4;
      tick();
      bus_wr = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL full_push_pop_ovf: got %b want 0", overflow);
      end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         checks++;
         if (cfg_we !== 1'b1 || cfg_addr !== 3'(k) || cfg_data !== 16'h00E0 + 16'(k)) begin
            errors++; $display("FAIL full_drain k=%0d: got we %b addr %0d data %h want 1 %0d %h",
                               k, cfg_we, cfg_addr, cfg_data, k, 16'h00E0 + 16'(k));
         end
      end
      accel_en = 1'b0;
      tick();
      accel_en = 1'b1;
      // Fill the FIFO while BUSY, then abort with a simultaneous push.
      load_cmd(16'h0F00, found);
      checks++;
      if (!found) begin
         errors++; $display("FAIL sim2_start_wait: got no acc_start want pulse");
      end
      for (int i = 0; i < 4; i++) begin
         bus_wr = 1'b1; bus_data = 16'h00F0 + 16'(i);
         tick();
      end
      accel_en = 1'b0; bus_wr = 1'b1; bus_data = 16'h00FF;
      tick();
      accel_en = 1'b1; bus_wr = 1'b0;
      checks++;
      if (overflow !== 1'b0 || cfg_we !== 1'b0 || acc_start !== 1'b0) begin
         errors++; $display("FAIL abort_push: got ovf %b we %b start %b want 0 0 0",
                            overflow, cfg_we, acc_start);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (cfg_we !== 1'b0) begin
            errors++; $display("FAIL abort_flushed k=%0d: got %b want 0", k, cfg_we);
         end
      end
   endtask

   task automatic test_watchdog();
      bit found;
      logic exp;
      load_cmd(16'h0A00, found);
      checks++;
      if (!found) begin
         errors++; $display("FAIL wd_start_wait: got no acc_start want pulse");
      end
`ifdef ACCEL_BRIDGE_WATCHDOG_EN
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp = (k == 16);
         checks++;
         if (timeout !== exp || accel_done !== exp) begin
            errors++; $display("FAIL wd_expire k=%0d: got to %b done %b want %b", k, timeout, accel_done, exp);
         end
      end
`else
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (k == 16 || k == 100) begin
            exp = 1'b0;
            checks++;
            if (timeout !== exp || accel_done !== exp) begin
               errors++; $display("FAIL no_wd k=%0d: got to %b done %b want 0 0", k, timeout, accel_done);
            end
         end
      end
      acc_finish = 1'b1;
      tick();
      acc_finish = 1'b0;
      checks++;
      if (accel_done !== 1'b1) begin
         errors++; $display("FAIL no_wd_still_busy: got %b want 1", accel_done);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [24:0] outs;
      #2;
      rst_n = 1'b0;
      #1;
      outs = {accel_done, cfg_we, cfg_addr, cfg_data, acc_start, overflow, timeout};
      checks++;
      if (outs !== 25'd0) begin
         errors++; $display("FAIL async_reset: got %h want 0", outs);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (accel_done !== 1'b0 || cfg_we !== 1'b0) begin
         errors++; $display("FAIL reset_after: got done %b we %b want 0 0", accel_done, cfg_we);
      end
   endtask

   initial begin
      test_reset();
      test_cmd_load();
      test_completion();
      test_overflow();
      test_abort();
      test_simultaneous();
      test_watchdog();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
